// File: rtl/fb_swap_controller.sv
// fb_swap_controller
//   Sequences a double-buffered frame store made of two single-port
//   synchronous RAM banks. The front bank feeds scanout; the back bank is
//   swept to CLEAR_COLOR, then drawn into by the renderer. The banks swap on
//   the first vsync after the renderer signals frame_done.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   vsync_pulse           one-cycle pulse at start of vertical blanking
//   draw_valid/ready      renderer pixel-write handshake
//   draw_x/y/color        renderer pixel coordinate and value
//   frame_done            renderer finished the back frame (pulse)
//   disp_x/y              scanout coordinate
//   disp_pixel            front pixel for (disp_x, disp_y), 1-cycle latency
//   bank{0,1}_addr/we/wdata/rdata  RAM bank interfaces
//   front_sel             index of the current front bank
//   clearing              high while the clear sweep runs
//   swap_count            completed swaps (wrapping)
//   miss_count            vsyncs without a swap (saturating)
module fb_swap_controller #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned ADDR_W      = 19,
  parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync_pulse,
  input  logic              draw_valid,
  output logic              draw_ready,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [2:0]        draw_color,
  input  logic              frame_done,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic [2:0]        disp_pixel,
  output logic [ADDR_W-1:0] bank0_addr,
  output logic              bank0_we,
  output logic [2:0]        bank0_wdata,
  input  logic [2:0]        bank0_rdata,
  output logic [ADDR_W-1:0] bank1_addr,
  output logic              bank1_we,
  output logic [2:0]        bank1_wdata,
  input  logic [2:0]        bank1_rdata,
  output logic              front_sel,
  output logic              clearing,
  output logic [15:0]       swap_count,
  output logic [15:0]       miss_count
);

  localparam logic [ADDR_W-1:0] H_W       = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [9:0]        H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);

  typedef enum logic [1:0] {S_CLEAR, S_DRAW, S_WAIT_SWAP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
  logic              front_sel_q, front_sel_d;
  logic [15:0]       swap_count_q, swap_count_d;
  logic [15:0]       miss_count_q, miss_count_d;
  logic              disp_in_q, disp_sel_q;

  logic [ADDR_W-1:0] draw_addr, disp_addr, back_addr;
  logic              draw_in, disp_in, back_we;
  logic [2:0]        back_wdata;

  assign draw_addr = ADDR_W'(draw_y) * H_W + ADDR_W'(draw_x);
  assign disp_addr = ADDR_W'(disp_y) * H_W + ADDR_W'(disp_x);
  assign draw_in   = (draw_x < H_LIM) && (draw_y < V_LIM);
  assign disp_in   = (disp_x < H_LIM) && (disp_y < V_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clear_addr_q <= '0;
      front_sel_q  <= 1'b0;
      swap_count_q <= '0;
      miss_count_q <= '0;
      disp_in_q    <= 1'b0;
      disp_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      front_sel_q  <= front_sel_d;
      swap_count_q <= swap_count_d;
      miss_count_q <= miss_count_d;
      // Bank select is captured with the read so a swap cannot split a read.
      disp_in_q    <= disp_in;
      disp_sel_q   <= front_sel_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    front_sel_d  = front_sel_q;
    swap_count_d = swap_count_q;
    miss_count_d = miss_count_q;
    back_addr    = clear_addr_q;
    back_wdata   = CLEAR_COLOR;
    back_we      = 1'b0;
    draw_ready   = 1'b0;
    clearing     = 1'b0;

    case (state_q)
      S_CLEAR: begin
        clearing = 1'b1;
        back_we  = 1'b1;
        if (clear_addr_q == LAST_ADDR) begin
          state_d      = S_DRAW;
          clear_addr_d = '0;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
        if (vsync_pulse && miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
      end
      S_DRAW: begin
        draw_ready = 1'b1;
        back_addr  = draw_addr;
        back_wdata = draw_color;
        back_we    = draw_valid && draw_in;
        if (frame_done) state_d = S_WAIT_SWAP;
        // Leaving DRAW this cycle still counts a simultaneous vsync as a miss.
        if (vsync_pulse && miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
      end
      S_WAIT_SWAP: begin
        if (vsync_pulse) begin
          front_sel_d  = ~front_sel_q;
          swap_count_d = swap_count_q + 1'b1;
          clear_addr_d = '0;
          state_d      = S_CLEAR;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    // Present reset-state outputs for as long as rst is held.
    if (rst) begin
      back_we    = 1'b0;
      draw_ready = 1'b0;
      clearing   = 1'b1;
    end
  end

  assign bank0_addr  = front_sel_q ? back_addr : disp_addr;
  assign bank0_we    = front_sel_q & back_we;
  assign bank0_wdata = back_wdata;
  assign bank1_addr  = front_sel_q ? disp_addr : back_addr;
  assign bank1_we    = ~front_sel_q & back_we;
  assign bank1_wdata = back_wdata;

  assign disp_pixel  = disp_in_q ? (disp_sel_q ? bank1_rdata : bank0_rdata) : 3'b000;
  assign front_sel   = front_sel_q;
  assign swap_count  = swap_count_q;
  assign miss_count  = miss_count_q;

endmodule
